// File: rtl/dsp_pkg.sv
// dsp_pkg: shared widths, OPMODE bit-field indices and X/Z select codes for the DSP post-adder
package dsp_pkg;
  localparam int P_W = 48;
  localparam int M_W = 36;
  localparam int OP_X_LSB = 0;
  localparam int OP_Z_LSB = 2;
  localparam int OP_CIN = 5;
  localparam int OP_SUB = 7;
  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M = 2'd1;
  localparam logic [1:0] X_P = 2'd2;
  localparam logic [1:0] X_DAB = 2'd3;
  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P = 2'd2;
  localparam logic [1:0] Z_C = 2'd3;
endpackage

// File: rtl/dsp_xz_sel.sv
// dsp_xz_sel: combinational X/Z operand muxes
// Ports: x_sel/z_sel select codes; m, dab, c, pcin, p_fb operand sources; x, z selected operands
module dsp_xz_sel
  import dsp_pkg::*;
(
  input  logic [1:0]     x_sel,
  input  logic [1:0]     z_sel,
  input  logic [M_W-1:0] m,
  input  logic [P_W-1:0] dab,
  input  logic [P_W-1:0] c,
  input  logic [P_W-1:0] pcin,
  input  logic [P_W-1:0] p_fb,
  output logic [P_W-1:0] x,
  output logic [P_W-1:0] z
);
  always_comb begin
    x = x_sel == X_M ? {{(P_W-M_W){1'b0}}, m} : x_sel == X_P ? p_fb : x_sel == X_DAB ? dab : '0;
    z = z_sel == Z_PCIN ? pcin : z_sel == Z_P ? p_fb : z_sel == Z_C ? c : '0;
  end
endmodule

// File: rtl/dsp_post_adder_acc.sv
// dsp_post_adder_acc: DSP post-adder/accumulator with P, carry-out, valid and sticky overflow
// Ports: clk, rst (sync active-high), ce_p, ce_carryin, in_valid, opmode[7:0], m[35:0], c/dab/pcin[47:0],
//   carryin, clr_ovf in; p/pcout[47:0], carryout, out_valid, ovf_sticky out
// Params: PREG, CARRYINREG, CARRYINSEL ("OPMODE5"/"CARRYIN"); define DSP_POST_SAT_EN for saturation
module dsp_post_adder_acc
  import dsp_pkg::*;
#(
  parameter int    PREG       = 1,
  parameter int    CARRYINREG = 1,
  parameter string CARRYINSEL = "OPMODE5"
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce_p,
  input  logic           ce_carryin,
  input  logic           in_valid,
  input  logic [7:0]     opmode,
  input  logic [M_W-1:0] m,
  input  logic [P_W-1:0] c,
  input  logic [P_W-1:0] dab,
  input  logic [P_W-1:0] pcin,
  input  logic           carryin,
  input  logic           clr_ovf,
  output logic [P_W-1:0] p,
  output logic [P_W-1:0] pcout,
  output logic           carryout,
  output logic           out_valid,
  output logic           ovf_sticky
);
  localparam bit CIN_FROM_OP = (CARRYINSEL == "OPMODE5");
  logic [P_W-1:0] p_q, p_d, p_fb, x, z, p_next;
  logic [P_W:0] r;
  logic carry_q, carry_d, valid_q, valid_d, ovf_q, ovf_d, cin_q, cin_d, cin_src, cin, sub;
  logic unused;
  assign unused = ^{opmode[6], opmode[4]};
  // Without PREG there is no register to feed back, so P select reads as zero
  assign p_fb = PREG != 0 ? p_q : '0;
  dsp_xz_sel u_xz (
    .x_sel(opmode[OP_X_LSB+:2]),
    .z_sel(opmode[OP_Z_LSB+:2]),
    .m(m),
    .dab(dab),
    .c(c),
    .pcin(pcin),
    .p_fb(p_fb),
    .x(x),
    .z(z)
  );
  always_comb begin
    cin_src = CIN_FROM_OP ? opmode[OP_CIN] : carryin;
    cin = CARRYINREG != 0 ? cin_q : cin_src;
    sub = opmode[OP_SUB];
    // r[48] is carry on add and borrow on subtract
    r = sub ? {1'b0, z} - ({1'b0, x} + {{P_W{1'b0}}, cin})
            : {1'b0, z} + {1'b0, x} + {{P_W{1'b0}}, cin};
`ifdef DSP_POST_SAT_EN
    p_next = r[P_W] ? (sub ? '0 : '1) : r[P_W-1:0];
`else
    p_next = r[P_W-1:0];
`endif
    cin_d = ce_carryin ? cin_src : cin_q;
    p_d = ce_p ? p_next : p_q;
    carry_d = ce_p ? r[P_W] : carry_q;
    valid_d = ce_p ? in_valid : valid_q;
    // a new overflow beats a simultaneous clear
    ovf_d = !ce_p ? ovf_q : (in_valid & r[P_W]) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      cin_q <= 1'b0;
    end else begin
      p_q <= p_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
      cin_q <= cin_d;
    end
  end
  assign p = PREG != 0 ? p_q : p_next;
  assign pcout = p;
  assign carryout = PREG != 0 ? carry_q : r[P_W];
  assign out_valid = PREG != 0 ? valid_q : in_valid;
  assign ovf_sticky = ovf_q;
endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// tb_dsp_post_adder_acc: directed self-checking bench for dsp_post_adder_acc (registered and combinational variants)
module tb_dsp_post_adder_acc;
  logic clk = 1'b0, rst = 1'b1, ce_p = 1'b1, ce_carryin = 1'b1, in_valid = 1'b0, carryin = 1'b0, clr_ovf = 1'b0;
  logic [7:0] opmode = 8'h00;
  logic [35:0] m = '0;
  logic [47:0] c = '0, dab = '0, pcin = '0;
  logic [47:0] p, pcout, p0, pcout0;
  logic carryout, out_valid, ovf_sticky, carryout0, out_valid0, ovf_sticky0;
  int checks = 0, errors = 0;
  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;
  always #5 clk = ~clk;
  dsp_post_adder_acc dut (
    .clk(clk), .rst(rst), .ce_p(ce_p), .ce_carryin(ce_carryin), .in_valid(in_valid), .opmode(opmode),
    .m(m), .c(c), .dab(dab), .pcin(pcin), .carryin(carryin), .clr_ovf(clr_ovf),
    .p(p), .pcout(pcout), .carryout(carryout), .out_valid(out_valid), .ovf_sticky(ovf_sticky)
  );
  dsp_post_adder_acc #(.PREG(0), .CARRYINREG(1), .CARRYINSEL("CARRYIN")) dut0 (
    .clk(clk), .rst(rst), .ce_p(ce_p), .ce_carryin(ce_carryin), .in_valid(in_valid), .opmode(opmode),
    .m(m), .c(c), .dab(dab), .pcin(pcin), .carryin(carryin), .clr_ovf(clr_ovf),
    .p(p0), .pcout(pcout0), .carryout(carryout0), .out_valid(out_valid0), .ovf_sticky(ovf_sticky0)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (p !== 48'd0) begin errors++; $display("FAIL reset_p got %h exp 0", p); end
    checks++; if (pcout !== 48'd0) begin errors++; $display("FAIL reset_pcout got %h exp 0", pcout); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("FAIL reset_carryout got %b exp 0", carryout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_sticky); end
    rst = 1'b0;
  endtask
  task automatic test_add();
    opmode = 8'h0D; m = 36'd5; c = 48'd10; in_valid = 1'b1;
    step();
    checks++; if (p !== 48'd15) begin errors++; $display("FAIL add_p got %0d exp 15", p); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("FAIL add_carryout got %b exp 0", carryout); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
  endtask
  task automatic test_accumulate();
    logic [47:0] exp_p [4] = '{48'd3, 48'd6, 48'd9, 48'd12};
    rst = 1'b1;
    step();
    rst = 1'b0; opmode = 8'h09; m = 36'd3; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (p !== exp_p[i]) begin errors++; $display("FAIL acc_p[%0d] got %0d exp %0d", i, p, exp_p[i]); end
      checks++; if (pcout !== exp_p[i]) begin errors++; $display("FAIL acc_pcout[%0d] got %0d exp %0d", i, pcout, exp_p[i]); end
    end
  endtask
  task automatic test_subtract();
    logic [47:0] exp_p;
    opmode = 8'hAF; c = 48'd100; dab = 48'd40; in_valid = 1'b1;
    step();
    step();
    checks++; if (p !== 48'd59) begin errors++; $display("FAIL sub_p got %0d exp 59", p); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("FAIL sub_carryout got %b exp 0", carryout); end
    c = 48'd0; dab = 48'd1;
    step();
`ifdef DSP_POST_SAT_EN
    exp_p = 48'd0;
`else
    exp_p = 48'hFFFF_FFFF_FFFE;
`endif
    checks++; if (p !== exp_p) begin errors++; $display("FAIL borrow_p got %h exp %h", p, exp_p); end
    checks++; if (carryout !== 1'b1) begin errors++; $display("FAIL borrow_carryout got %b exp 1", carryout); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL borrow_ovf got %b exp 1", ovf_sticky); end
  endtask
  task automatic test_overflow();
    logic [47:0] exp_p;
    rst = 1'b1;
    step();
    rst = 1'b0; opmode = 8'h0D; c = ONES; m = 36'd1; in_valid = 1'b1;
    step();
`ifdef DSP_POST_SAT_EN
    exp_p = ONES;
`else
    exp_p = 48'd0;
`endif
    checks++; if (p !== exp_p) begin errors++; $display("FAIL ovf_p got %h exp %h", p, exp_p); end
    checks++; if (carryout !== 1'b1) begin errors++; $display("FAIL ovf_carryout got %b exp 1", carryout); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf_sticky); end
    c = 48'd0; clr_ovf = 1'b1;
    step();
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf_sticky); end
    checks++; if (p !== 48'd1) begin errors++; $display("FAIL ovf_clear_p got %0d exp 1", p); end
    c = ONES;
    step();
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", ovf_sticky); end
    clr_ovf = 1'b0;
  endtask
  task automatic test_enables_reset();
    ce_p = 1'b0; c = 48'd5; m = 36'd9; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (p !== 48'd0) begin errors++; $display("FAIL hold_p[%0d] got %h exp 0", i, p); end
      checks++; if (carryout !== 1'b1) begin errors++; $display("FAIL hold_carryout[%0d] got %b exp 1", i, carryout); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", i, out_valid); end
    end
    ce_p = 1'b1; opmode = 8'h09; m = 36'd3; in_valid = 1'b1;
    step();
    step();
    checks++; if (p !== 48'd6) begin errors++; $display("FAIL preacc_p got %0d exp 6", p); end
    rst = 1'b1; ce_p = 1'b0;
    step();
    checks++; if (p !== 48'd0 || pcout !== 48'd0) begin errors++; $display("FAIL rst_mid_p got %h/%h exp 0", p, pcout); end
    checks++; if (carryout !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got %b%b exp 00", carryout, out_valid); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got %b exp 0", ovf_sticky); end
    rst = 1'b0; ce_p = 1'b1; m = 36'd7;
    step();
    checks++; if (p !== 48'd7) begin errors++; $display("FAIL post_rst_p got %0d exp 7", p); end
  endtask
  task automatic test_params();
    step();
    opmode = 8'h0D; m = 36'd5; c = 48'd10; carryin = 1'b0; in_valid = 1'b1;
    #1;
    checks++; if (p0 !== 48'd15) begin errors++; $display("FAIL comb_p got %0d exp 15", p0); end
    checks++; if (pcout0 !== 48'd15) begin errors++; $display("FAIL comb_pcout got %0d exp 15", pcout0); end
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL comb_valid got %b exp 1", out_valid0); end
    opmode = 8'h09; m = 36'd3;
    #1;
    checks++; if (p0 !== 48'd3) begin errors++; $display("FAIL comb_pfb got %0d exp 3", p0); end
    opmode = 8'h0D; m = 36'd5; carryin = 1'b1;
    #1;
    checks++; if (p0 !== 48'd15) begin errors++; $display("FAIL cin_early got %0d exp 15", p0); end
    step();
    carryin = 1'b0;
    #1;
    checks++; if (p0 !== 48'd16) begin errors++; $display("FAIL cin_late got %0d exp 16", p0); end
    step();
    checks++; if (p0 !== 48'd15) begin errors++; $display("FAIL cin_gone got %0d exp 15", p0); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_accumulate();
    test_subtract();
    test_overflow();
    test_enables_reset();
    test_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
